// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencer.
package cpu_pkg;

   localparam int RETIRE_W_DEF = 16;

   localparam logic [7:0] OP_LOAD     = 8'h40;
   localparam logic [7:0] OP_STOR     = 8'h44;
   localparam logic [7:0] OP_JCOND    = 8'h4C;
   localparam logic [7:0] OP_HALT     = 8'hFF;
   localparam logic [3:0] OP_BCOND_HI = 4'hC;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_FETCH_WAIT,
      ST_DECODE,
      ST_EXEC,
      ST_MEM_RD,
      ST_MEM_WB,
      ST_MEM_WR,
      ST_BRANCH,
      ST_HALT
   } seq_state_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LOAD,
      CLS_STOR,
      CLS_BRANCH,
      CLS_HALT
   } instr_class_t;

   // Terminal states retire the instruction and always leave after one cycle.
   function automatic logic is_terminal(input seq_state_t s);
      return (s == ST_EXEC) || (s == ST_MEM_WB) || (s == ST_MEM_WR) || (s == ST_BRANCH);
   endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bus between decoder/datapath and the sequencer.
// The step strobe exists only when SEQ_SINGLE_STEP_EN is defined.
interface cpu_sequencer_if #(parameter int RETIRE_W = cpu_pkg::RETIRE_W_DEF);

   logic                run;
   logic [7:0]          opcode;
   logic                cond_true;
`ifdef SEQ_SINGLE_STEP_EN
   logic                step;
`endif
   logic                pc_en;
   logic                pc_load;
   logic                ls_cntl;
   logic                ir_en;
   logic                ram_we;
   logic                reg_we;
   logic                wb_sel;
   logic                flags_en;
   logic                busy;
   logic                halted;
   logic [RETIRE_W-1:0] retired;

`ifdef SEQ_SINGLE_STEP_EN
   modport master (
      output run, opcode, cond_true, step,
      input  pc_en, pc_load, ls_cntl, ir_en, ram_we, reg_we, wb_sel, flags_en,
             busy, halted, retired
   );

   modport slave (
      input  run, opcode, cond_true, step,
      output pc_en, pc_load, ls_cntl, ir_en, ram_we, reg_we, wb_sel, flags_en,
             busy, halted, retired
   );
`else
   modport master (
      output run, opcode, cond_true,
      input  pc_en, pc_load, ls_cntl, ir_en, ram_we, reg_we, wb_sel, flags_en,
             busy, halted, retired
   );

   modport slave (
      input  run, opcode, cond_true,
      output pc_en, pc_load, ls_cntl, ir_en, ram_we, reg_we, wb_sel, flags_en,
             busy, halted, retired
   );
`endif

endinterface

// File: rtl/seq_class_decode.sv
// Combinational opcode-to-instruction-class decode for the sequencer.
module seq_class_decode
   import cpu_pkg::*;
(
   input  logic [7:0]   opcode,
   output instr_class_t op_class
);

   logic [3:0] op_hi;

   assign op_hi = opcode[7:4];

   always_comb begin
      op_class = CLS_ALU;
      if (opcode == OP_LOAD)
         op_class = CLS_LOAD;
      else if (opcode == OP_STOR)
         op_class = CLS_STOR;
      else if ((opcode == OP_JCOND) || (op_hi == OP_BCOND_HI))
         op_class = CLS_BRANCH;
      else if (opcode == OP_HALT)
         op_class = CLS_HALT;
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer driving datapath strobes.
// Optional SEQ_SINGLE_STEP_EN: one instruction per rising edge of bus.step.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int RETIRE_W = RETIRE_W_DEF
)
(
   input  logic           clk,
   input  logic           reset,
   cpu_sequencer_if.slave bus
);

   seq_state_t          state;
   seq_state_t          next_state;
   instr_class_t        dec_class;
   instr_class_t        class_q;
   logic                start_ok;
   logic [RETIRE_W-1:0] retired_q;

   logic pc_en_q, ls_cntl_q, ir_en_q, ram_we_q, reg_we_q;
   logic wb_sel_q, flags_en_q, branch_q, busy_q, halted_q;

   seq_class_decode u_class_decode (
      .opcode   (bus.opcode),
      .op_class (dec_class)
   );

`ifdef SEQ_SINGLE_STEP_EN
   logic step_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         step_q <= 1'b0;
      else
         step_q <= bus.step;
   end

   assign start_ok = bus.run & bus.step & ~step_q;
`else
   assign start_ok = bus.run;
`endif

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:       if (start_ok) next_state = ST_FETCH;
         ST_FETCH:      next_state = ST_FETCH_WAIT;
         ST_FETCH_WAIT: next_state = ST_DECODE;
         ST_DECODE: begin
            case (dec_class)
               CLS_LOAD:   next_state = ST_MEM_RD;
               CLS_STOR:   next_state = ST_MEM_WR;
               CLS_BRANCH: next_state = ST_BRANCH;
               CLS_HALT:   next_state = ST_HALT;
               default:    next_state = ST_EXEC;
            endcase
         end
         ST_MEM_RD:     next_state = (class_q == CLS_LOAD) ? ST_MEM_WB : ST_IDLE;
         ST_EXEC, ST_MEM_WB, ST_MEM_WR, ST_BRANCH: begin
`ifdef SEQ_SINGLE_STEP_EN
            next_state = ST_IDLE;
`else
            next_state = bus.run ? ST_FETCH : ST_IDLE;
`endif
         end
         ST_HALT:       next_state = ST_HALT;
         default:       next_state = ST_IDLE;
      endcase
   end

   // Strobes are registered from the next state so each one is a clean Moore output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         class_q    <= CLS_ALU;
         retired_q  <= '0;
         pc_en_q    <= 1'b0;
         ls_cntl_q  <= 1'b0;
         ir_en_q    <= 1'b0;
         ram_we_q   <= 1'b0;
         reg_we_q   <= 1'b0;
         wb_sel_q   <= 1'b0;
         flags_en_q <= 1'b0;
         branch_q   <= 1'b0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state <= next_state;
         if (state == ST_DECODE)
            class_q <= dec_class;
         if (is_terminal(state) || ((next_state == ST_HALT) && (state != ST_HALT)))
            retired_q <= retired_q + RETIRE_W'(1);
         pc_en_q    <= (next_state == ST_FETCH_WAIT);
         ir_en_q    <= (next_state == ST_FETCH_WAIT);
         ls_cntl_q  <= (next_state == ST_MEM_RD) || (next_state == ST_MEM_WB) ||
                       (next_state == ST_MEM_WR);
         ram_we_q   <= (next_state == ST_MEM_WR);
         reg_we_q   <= (next_state == ST_EXEC) || (next_state == ST_MEM_WB);
         wb_sel_q   <= (next_state == ST_MEM_WB);
         flags_en_q <= (next_state == ST_EXEC);
         branch_q   <= (next_state == ST_BRANCH);
         busy_q     <= (next_state != ST_IDLE) && (next_state != ST_HALT);
         halted_q   <= (next_state == ST_HALT);
      end
   end

   assign bus.pc_en    = pc_en_q;
   assign bus.pc_load  = branch_q & bus.cond_true;
   assign bus.ls_cntl  = ls_cntl_q;
   assign bus.ir_en    = ir_en_q;
   assign bus.ram_we   = ram_we_q;
   assign bus.reg_we   = reg_we_q;
   assign bus.wb_sel   = wb_sel_q;
   assign bus.flags_en = flags_en_q;
   assign bus.busy     = busy_q;
   assign bus.halted   = halted_q;
   assign bus.retired  = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: random instruction mix against a cycle-table model.
module tb_cpu_sequencer;

   localparam int W = 8;

   localparam int K_ALU  = 0;
   localparam int K_LOAD = 1;
   localparam int K_STOR = 2;
   localparam int K_BR   = 3;
   localparam int K_HALT = 4;

   localparam int B_PC_EN   = 9;
   localparam int B_PC_LOAD = 8;
   localparam int B_LS      = 7;
   localparam int B_IR      = 6;
   localparam int B_RAM_WE  = 5;
   localparam int B_REG_WE  = 4;
   localparam int B_WB      = 3;
   localparam int B_FLAGS   = 2;
   localparam int B_BUSY    = 1;
   localparam int B_HALTED  = 0;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   cpu_sequencer_if #(.RETIRE_W(W)) bus ();

   cpu_sequencer #(.RETIRE_W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int          compared   = 0;
   int          mismatched = 0;
   int unsigned ret_model  = 0;

   logic [9:0]   obs_vec [1:6];
   logic [W-1:0] obs_ret [1:6];
   int           obs_len;

   function automatic logic [9:0] observe();
      return {bus.pc_en, bus.pc_load, bus.ls_cntl, bus.ir_en, bus.ram_we,
              bus.reg_we, bus.wb_sel, bus.flags_en, bus.busy, bus.halted};
   endfunction

   function automatic int op_kind(input logic [7:0] op);
      if (op == 8'h40) return K_LOAD;
      if (op == 8'h44) return K_STOR;
      if (op == 8'h4C || op[7:4] == 4'hC) return K_BR;
      if (op == 8'hFF) return K_HALT;
      return K_ALU;
   endfunction

   function automatic int instr_len(input logic [7:0] op);
      return (op_kind(op) == K_LOAD) ? 5 : 4;
   endfunction

   // Expected strobes for cycle c (1 = FETCH) of an instruction.
   function automatic logic [9:0] exp_vec(input logic [7:0] op, input int c, input logic cond);
      logic [9:0] v;
      int k;
      v = '0;
      k = op_kind(op);
      if (c == 1 || c == 3) begin
         v[B_BUSY] = 1'b1;
      end else if (c == 2) begin
         v[B_PC_EN] = 1'b1; v[B_IR] = 1'b1; v[B_BUSY] = 1'b1;
      end else if (c == 4) begin
         if (k == K_HALT) begin
            v[B_HALTED] = 1'b1;
         end else begin
            v[B_BUSY] = 1'b1;
            if (k == K_ALU)  begin v[B_REG_WE] = 1'b1; v[B_FLAGS] = 1'b1; end
            if (k == K_LOAD) v[B_LS] = 1'b1;
            if (k == K_STOR) begin v[B_LS] = 1'b1; v[B_RAM_WE] = 1'b1; end
            if (k == K_BR)   v[B_PC_LOAD] = cond;
         end
      end else if (c == 5) begin
         v[B_LS] = 1'b1; v[B_REG_WE] = 1'b1; v[B_WB] = 1'b1; v[B_BUSY] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [W-1:0] exp_ret(input logic [7:0] op, input int c);
      int unsigned r;
      r = ret_model;
      if (op_kind(op) == K_HALT && c == 4) r = r + 1;
      return W'(r);
   endfunction

   function automatic logic [7:0] rand_alu_op();
      logic [7:0] op;
      do op = 8'($urandom);
      while (op == 8'h40 || op == 8'h44 || op == 8'h4C || op == 8'hFF || op[7:4] == 4'hC);
      return op;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction from FETCH to its last cycle, capturing outputs; run drops after cycle drop_at.
   task automatic drive_instr(input logic [7:0] op, input logic cond, input int drop_at);
      int n;
      n = instr_len(op);
      bus.opcode    = op;
      bus.cond_true = cond;
      for (int c = 1; c <= n; c++) begin
         tick();
         obs_vec[c] = observe();
         obs_ret[c] = bus.retired;
         if (c == drop_at) bus.run = 1'b0;
      end
      obs_len = n;
   endtask

   task automatic test_reset();
      #12;
      compared++;
      if (observe() !== 10'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_strobes: got %b expected %b", observe(), 10'b0);
      end
      compared++;
      if (bus.retired !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_retired: got %0d expected 0", bus.retired);
      end
      reset = 1'b1;
      tick();
      tick();
      compared++;
      if (observe() !== 10'b0) begin
         mismatched++;
         $display("[TB] FAIL idle_no_run: got %b expected %b", observe(), 10'b0);
      end
   endtask

   task automatic test_alu();
      bus.run = 1'b1;
      drive_instr(8'h05, 1'b0, 0);
      for (int c = 1; c <= obs_len; c++) begin
         compared++;
         if (obs_vec[c] !== exp_vec(8'h05, c, 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL alu_strobes c%0d: got %b expected %b", c, obs_vec[c], exp_vec(8'h05, c, 1'b0));
         end
         compared++;
         if (obs_ret[c] !== exp_ret(8'h05, c)) begin
            mismatched++;
            $display("[TB] FAIL alu_retired c%0d: got %0d expected %0d", c, obs_ret[c], exp_ret(8'h05, c));
         end
      end
      ret_model++;
   endtask

   task automatic test_load();
      drive_instr(8'h40, 1'b0, 0);
      for (int c = 1; c <= obs_len; c++) begin
         compared++;
         if (obs_vec[c] !== exp_vec(8'h40, c, 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL load_strobes c%0d: got %b expected %b", c, obs_vec[c], exp_vec(8'h40, c, 1'b0));
         end
         compared++;
         if (obs_ret[c] !== exp_ret(8'h40, c)) begin
            mismatched++;
            $display("[TB] FAIL load_retired c%0d: got %0d expected %0d", c, obs_ret[c], exp_ret(8'h40, c));
         end
      end
      ret_model++;
   endtask

   task automatic test_stor_branch();
      logic [7:0] ops [4];
      logic       conds [4];
      ops   = '{8'h44, 8'hC1, 8'hC1, 8'h4C};
      conds = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive_instr(ops[i], conds[i], 0);
         for (int c = 1; c <= obs_len; c++) begin
            compared++;
            if (obs_vec[c] !== exp_vec(ops[i], c, conds[i])) begin
               mismatched++;
               $display("[TB] FAIL stor_branch_strobes op%h c%0d: got %b expected %b",
                        ops[i], c, obs_vec[c], exp_vec(ops[i], c, conds[i]));
            end
            compared++;
            if (obs_ret[c] !== exp_ret(ops[i], c)) begin
               mismatched++;
               $display("[TB] FAIL stor_branch_retired op%h c%0d: got %0d expected %0d",
                        ops[i], c, obs_ret[c], exp_ret(ops[i], c));
            end
         end
         ret_model++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] op;
      logic       cond;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0:       op = rand_alu_op();
            1:       op = 8'h40;
            2:       op = 8'h44;
            3:       op = 8'h4C;
            default: op = {4'hC, 4'($urandom)};
         endcase
         cond = 1'($urandom);
         drive_instr(op, cond, 0);
         for (int c = 1; c <= obs_len; c++) begin
            compared++;
            if (obs_vec[c] !== exp_vec(op, c, cond)) begin
               mismatched++;
               $display("[TB] FAIL random_strobes op%h c%0d: got %b expected %b",
                        op, c, obs_vec[c], exp_vec(op, c, cond));
            end
            compared++;
            if (obs_ret[c] !== exp_ret(op, c)) begin
               mismatched++;
               $display("[TB] FAIL random_retired op%h c%0d: got %0d expected %0d",
                        op, c, obs_ret[c], exp_ret(op, c));
            end
         end
         ret_model++;
      end
   endtask

   task automatic test_run_drop();
      drive_instr(8'h12, 1'b0, 3);
      for (int c = 1; c <= obs_len; c++) begin
         compared++;
         if (obs_vec[c] !== exp_vec(8'h12, c, 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL run_drop_strobes c%0d: got %b expected %b", c, obs_vec[c], exp_vec(8'h12, c, 1'b0));
         end
      end
      ret_model++;
      tick();
      compared++;
      if (observe() !== 10'b0) begin
         mismatched++;
         $display("[TB] FAIL run_drop_idle: got %b expected %b", observe(), 10'b0);
      end
      compared++;
      if (bus.retired !== W'(ret_model)) begin
         mismatched++;
         $display("[TB] FAIL run_drop_retired: got %0d expected %0d", bus.retired, W'(ret_model));
      end
      tick();
      compared++;
      if (observe() !== 10'b0) begin
         mismatched++;
         $display("[TB] FAIL run_drop_stays_idle: got %b expected %b", observe(), 10'b0);
      end
   endtask

   task automatic test_retired_wrap();
      int n;
      logic [7:0] op;
      n = 256 - int'(ret_model % 256);
      bus.run = 1'b1;
      for (int i = 0; i < n; i++) begin
         op = rand_alu_op();
         drive_instr(op, 1'b0, 0);
         compared++;
         if (obs_ret[4] !== exp_ret(op, 4)) begin
            mismatched++;
            $display("[TB] FAIL wrap_retired i%0d: got %0d expected %0d", i, obs_ret[4], exp_ret(op, 4));
         end
         ret_model++;
      end
      bus.run = 1'b0;
      tick();
      compared++;
      if (bus.retired !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL wrap_to_zero: got %0d expected 0", bus.retired);
      end
   endtask

   task automatic test_reset_mid_store();
      bus.run = 1'b1;
      drive_instr(8'h44, 1'b0, 0);
      compared++;
      if (obs_vec[4] !== exp_vec(8'h44, 4, 1'b0)) begin
         mismatched++;
         $display("[TB] FAIL mid_store_write: got %b expected %b", obs_vec[4], exp_vec(8'h44, 4, 1'b0));
      end
      #2;
      reset = 1'b0;
      #1;
      compared++;
      if (observe() !== 10'b0) begin
         mismatched++;
         $display("[TB] FAIL async_reset_strobes: got %b expected %b", observe(), 10'b0);
      end
      compared++;
      if (bus.retired !== '0) begin
         mismatched++;
         $display("[TB] FAIL async_reset_retired: got %0d expected 0", bus.retired);
      end
      ret_model = 0;
      bus.run = 1'b0;
      #2;
      reset = 1'b1;
      tick();
      compared++;
      if (observe() !== 10'b0) begin
         mismatched++;
         $display("[TB] FAIL post_reset_idle: got %b expected %b", observe(), 10'b0);
      end
   endtask

   task automatic test_halt();
      logic [9:0] halt_vec;
      bus.run = 1'b1;
      drive_instr(8'hFF, 1'b0, 0);
      for (int c = 1; c <= obs_len; c++) begin
         compared++;
         if (obs_vec[c] !== exp_vec(8'hFF, c, 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL halt_strobes c%0d: got %b expected %b", c, obs_vec[c], exp_vec(8'hFF, c, 1'b0));
         end
         compared++;
         if (obs_ret[c] !== exp_ret(8'hFF, c)) begin
            mismatched++;
            $display("[TB] FAIL halt_retired c%0d: got %0d expected %0d", c, obs_ret[c], exp_ret(8'hFF, c));
         end
      end
      ret_model++;
      halt_vec = '0;
      halt_vec[B_HALTED] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         compared++;
         if (observe() !== halt_vec) begin
            mismatched++;
            $display("[TB] FAIL halt_sticky i%0d: got %b expected %b", i, observe(), halt_vec);
         end
         compared++;
         if (bus.retired !== W'(ret_model)) begin
            mismatched++;
            $display("[TB] FAIL halt_retired_hold i%0d: got %0d expected %0d", i, bus.retired, W'(ret_model));
         end
      end
   endtask

   initial begin
      bus.run       = 1'b0;
      bus.opcode    = 8'h00;
      bus.cond_true = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      bus.step      = 1'b0;
`endif
      test_reset();
      test_alu();
      test_load();
      test_stor_branch();
      test_back_to_back();
      test_run_drop();
      test_retired_wrap();
      test_reset_mid_store();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit CPU datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the control strobes for:
- program counter (increment / load)
- RAM address mux and port-A write enable
- instruction register load
- register-file write and writeback select
- flag register

It sits between the instruction decoder (which supplies `opcode`) and the datapath, and replaces ad-hoc per-opcode strobe generation with a single state machine.

## Interface
Parameters:
- `RETIRE_W`, default 16: width of the retired-instruction counter.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 lets the sequencer start new instructions.
- `opcode`  in  8  `{instr[15:12], instr[7:4]}` from the decoder; valid from DECODE onward.
- `cond_true`  in  1  branch condition result from flag compare; sampled in BRANCH.
- `step`  in  1  single-step pulse (present only with `SEQ_SINGLE_STEP_EN`).
- `pc_en`  out  1  PC advances by one.
- `pc_load`  out  1  PC loads the branch target.
- `ls_cntl`  out  1  RAM address select: 0 = PC, 1 = register (`mux_b_out`).
- `ir_en`  out  1  instruction register captures RAM port-A data.
- `ram_we`  out  1  RAM port-A write enable.
- `reg_we`  out  1  register-file write enable.
- `wb_sel`  out  1  writeback source: 0 = ALU, 1 = RAM data.
- `flags_en`  out  1  flag register update.
- `busy`  out  1  high in any state except IDLE and HALT.
- `halted`  out  1  high in HALT.
- `retired`  out  `RETIRE_W`  count of completed instructions.

## Operation
- States are IDLE, FETCH, FETCH_WAIT, DECODE, EXEC, MEM_RD, MEM_WB, MEM_WR, BRANCH and HALT.
- Instruction classes are decoded from `opcode` in DECODE and latched into a class register:
  - LOAD = 8'h40
  - STOR = 8'h44
  - JCOND = 8'h4C
  - BCOND = `opcode[7:4]` == 4'hC
  - HALT = 8'hFF
  - ALU = all others
- Transitions:
  - IDLE → FETCH when `run` = 1.
  - FETCH → FETCH_WAIT → DECODE.
  - DECODE → EXEC (ALU), MEM_RD (LOAD), MEM_WR (STOR), BRANCH (JCOND/BCOND), HALT (HALT).
  - MEM_RD → MEM_WB.
  - EXEC, MEM_WB, MEM_WR and BRANCH are terminal states. From a terminal state: → FETCH if `run` = 1, else → IDLE.
  - HALT is sticky until `reset`.
- Strobes are a Moore decode of the registered state; every strobe not listed for a state is 0 in that state:
  - FETCH: `ls_cntl` = 0.
  - FETCH_WAIT: `ir_en` = 1, `pc_en` = 1.
  - EXEC: `reg_we` = 1, `flags_en` = 1, `wb_sel` = 0.
  - MEM_RD: `ls_cntl` = 1.
  - MEM_WB: `ls_cntl` = 1, `reg_we` = 1, `wb_sel` = 1.
  - MEM_WR: `ls_cntl` = 1, `ram_we` = 1.
  - BRANCH: `pc_load` = `cond_true`.
- `retired` increments by 1 on each transition out of a terminal state and on entry to HALT. It wraps from all-ones to 0.
- `run` dropped mid-instruction: the current instruction completes, then the sequencer enters IDLE. It never aborts between states.

## Timing
- Cycle counts, FETCH through terminal state:
  - ALU: 4
  - LOAD: 5
  - STOR: 4
  - branch: 4
  - HALT: 3 to reach HALT
- RAM read latency is 1 cycle: the address is presented in FETCH, data is captured in FETCH_WAIT. The same applies to MEM_RD → MEM_WB.
- `pc_en` and `pc_load` can never be high in the same cycle.
- Reset values:
  - state = IDLE
  - all strobes = 0
  - `busy` = 0, `halted` = 0
  - `retired` = 0
- Reset asserted mid-instruction forces IDLE asynchronously; no partial write completes after reset is asserted.
- Reset release: the first FETCH occurs on the first rising edge with `reset` = 1 and `run` = 1 sampled.

## Configuration
- `SEQ_SINGLE_STEP_EN`: adds the `step` port.
  - With the macro, after every terminal state (and from IDLE) the sequencer waits in IDLE until a cycle with `step` = 1 and `run` = 1. Exactly one instruction executes per `step` pulse. A `step` held high for several cycles counts only on its rising edge (one registered edge detector).
  - Without the macro: no `step` port, no edge detector, and `run` alone gates progress.

## Structure
- Shared package `cpu_pkg` holds:
  - state enum
  - class enum
  - opcode constants `OP_LOAD`, `OP_STOR`, `OP_JCOND`, `OP_HALT`, `OP_BCOND_HI`
  - `RETIRE_W` default
- One sub-module, `seq_class_decode`: combinational `opcode` → class, instantiated once; its output is registered in DECODE.
- Next-state logic, strobe decode and the retired counter stay in `cpu_sequencer`.

## Test plan
- Reset and `run` = 1, ALU opcode 8'h05 → states FETCH, FETCH_WAIT, DECODE, EXEC. `reg_we` and `flags_en` are high in cycle 4 only; `retired` = 1.
- LOAD 8'h40 → `ls_cntl` = 1 in cycles 4–5; `reg_we` = 1 and `wb_sel` = 1 in cycle 5 only; `ram_we` stays 0.
- STOR 8'h44, then BCOND 8'hC1:
  - STOR: `ram_we` = 1 only in cycle 4.
  - BCOND with `cond_true` = 1: `pc_load` = 1 in its BRANCH cycle.
  - BCOND with `cond_true` = 0: `pc_load` = 0.
- HALT 8'hFF → `halted` = 1 and `busy` = 0 from cycle 4; stays there for 20 cycles with `run` = 1; `retired` increments once.
- Async `reset` low during MEM_WR → `ram_we` drops in the same cycle; state = IDLE; `retired` = 0.
- Preload `retired` to 16'hFFFF and run one ALU instruction → `retired` = 16'h0000.
- `run` dropped during DECODE → the instruction completes, then IDLE.
